// File: rtl/choice_capture.sv
// Round controller: countdown, draw window, first-press capture per player, foul flags.
// Define CHOICE_SYNC_EN to insert two-flop synchronizers on the button inputs.
module choice_capture #(
    parameter int unsigned COUNT_CYCLES  = 8,
    parameter int unsigned WINDOW_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] p1_btn,
    input  logic [3:0] p2_btn,
    output logic [3:0] p1_choice,
    output logic [3:0] p2_choice,
    output logic       choice_valid,
    output logic       p1_foul,
    output logic       p2_foul,
    output logic       busy
);

    localparam int unsigned BTN_W      = 4;
    localparam int unsigned MAX_CYCLES = (COUNT_CYCLES > WINDOW_CYCLES) ? COUNT_CYCLES : WINDOW_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_DRAW,
        S_RESULT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BTN_W-1:0]   p1_prev_q, p2_prev_q;
    logic [BTN_W-1:0]   p1_lock_q, p1_lock_d, p2_lock_q, p2_lock_d;
    logic [BTN_W-1:0]   p1_choice_q, p1_choice_d, p2_choice_q, p2_choice_d;
    logic               p1_foul_q, p1_foul_d, p2_foul_q, p2_foul_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [BTN_W-1:0]   p1_btn_s, p2_btn_s;
    logic [BTN_W-1:0]   p1_new, p2_new;
    logic               both_done;

`ifdef CHOICE_SYNC_EN
    logic [BTN_W-1:0] p1_meta_q, p1_sync_q, p2_meta_q, p2_sync_q;

    // Two-flop synchronizers for asynchronous board buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_meta_q <= '0;
            p1_sync_q <= '0;
            p2_meta_q <= '0;
            p2_sync_q <= '0;
        end else begin
            p1_meta_q <= p1_btn;
            p1_sync_q <= p1_meta_q;
            p2_meta_q <= p2_btn;
            p2_sync_q <= p2_meta_q;
        end
    end

    assign p1_btn_s = p1_sync_q;
    assign p2_btn_s = p2_sync_q;
`else
    assign p1_btn_s = p1_btn;
    assign p2_btn_s = p2_btn;
`endif

    // Rising-edge press events; a button held across a state change never fires
    assign p1_new = p1_btn_s & ~p1_prev_q;
    assign p2_new = p2_btn_s & ~p2_prev_q;

    function automatic logic [BTN_W-1:0] lowest_bit(input logic [BTN_W-1:0] v);
        return v & (~v + BTN_W'(1));
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_lock_d   = p1_lock_q;
        p2_lock_d   = p2_lock_q;
        p1_foul_d   = p1_foul_q;
        p2_foul_d   = p2_foul_q;
        p1_choice_d = p1_choice_q;
        p2_choice_d = p2_choice_q;
        valid_d     = 1'b0;
        both_done   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_COUNTDOWN;
                    cnt_d       = CNT_W'(COUNT_CYCLES - 1);
                    p1_lock_d   = '0;
                    p2_lock_d   = '0;
                    p1_foul_d   = 1'b0;
                    p2_foul_d   = 1'b0;
                    p1_choice_d = '0;
                    p2_choice_d = '0;
                end
            end
            S_COUNTDOWN: begin
                if (|p1_new) p1_foul_d = 1'b1;
                if (|p2_new) p2_foul_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DRAW;
                    cnt_d   = CNT_W'(WINDOW_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAW: begin
                if (!p1_foul_q && (p1_lock_q == '0) && (|p1_new)) p1_lock_d = lowest_bit(p1_new);
                if (!p2_foul_q && (p2_lock_q == '0) && (|p2_new)) p2_lock_d = lowest_bit(p2_new);
                // Same-cycle locks count toward the early exit
                both_done = (p1_foul_q || (|p1_lock_d)) && (p2_foul_q || (|p2_lock_d));
                if (both_done || (cnt_q == '0)) begin
                    state_d     = S_RESULT;
                    p1_choice_d = p1_foul_q ? '0 : p1_lock_d;
                    p2_choice_d = p2_foul_q ? '0 : p2_lock_d;
                    valid_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p1_prev_q   <= '0;
            p2_prev_q   <= '0;
            p1_lock_q   <= '0;
            p2_lock_q   <= '0;
            p1_foul_q   <= 1'b0;
            p2_foul_q   <= 1'b0;
            p1_choice_q <= '0;
            p2_choice_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_prev_q   <= p1_btn_s;
            p2_prev_q   <= p2_btn_s;
            p1_lock_q   <= p1_lock_d;
            p2_lock_q   <= p2_lock_d;
            p1_foul_q   <= p1_foul_d;
            p2_foul_q   <= p2_foul_d;
            p1_choice_q <= p1_choice_d;
            p2_choice_q <= p2_choice_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign p1_choice    = p1_choice_q;
    assign p2_choice    = p2_choice_q;
    assign choice_valid = valid_q;
    assign p1_foul      = p1_foul_q;
    assign p2_foul      = p2_foul_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_choice_capture.sv
// Directed bench for choice_capture; expected round outcomes are queued at stimulus
// time and checked when choice_valid fires. Cycle 1 is the first cycle after start is sampled.
module tb_choice_capture;

`ifdef CHOICE_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    typedef struct packed {
        logic [3:0] p1;
        logic [3:0] p2;
        logic       f1;
        logic       f2;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] p1_btn, p2_btn;
    logic [3:0] p1_choice, p2_choice;
    logic       choice_valid, p1_foul, p2_foul, busy;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;

    choice_capture #(.COUNT_CYCLES(8), .WINDOW_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .p1_btn      (p1_btn),
        .p2_btn      (p2_btn),
        .p1_choice   (p1_choice),
        .p2_choice   (p2_choice),
        .choice_valid(choice_valid),
        .p1_foul     (p1_foul),
        .p2_foul     (p2_foul),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic start_round(input exp_t e);
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    // Wait for the strobe, compare against the oldest queued outcome, then check it drops
    task automatic finish_round(input int exp_cyc);
        exp_t e;
        int   k;
        k = 0;
        while (!choice_valid && k < 40) begin
            tick();
            k++;
        end
        if (!choice_valid) chk("valid_timeout", 32'(choice_valid), 32'd1);
        chk("valid_cycle", 32'(cyc), 32'(exp_cyc));
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("p1_choice", 32'(p1_choice), 32'(e.p1));
            chk("p2_choice", 32'(p2_choice), 32'(e.p2));
            chk("p1_foul", 32'(p1_foul), 32'(e.f1));
            chk("p2_foul", 32'(p2_foul), 32'(e.f2));
        end
        chk("busy_in_result", 32'(busy), 32'd1);
        tick();
        chk("valid_single", 32'(choice_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        p1_btn = '0;
        p2_btn = '0;
        #12;
        chk("rst_outputs", 32'({p1_choice, p2_choice, choice_valid, p1_foul, p2_foul, busy}), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Normal round: p1 at DRAW cycle 2, p2 at DRAW cycle 5
        start_round('{p1: 4'b0010, p2: 4'b1000, f1: 1'b0, f2: 1'b0});
        chk("busy_after_start", 32'(busy), 32'd1);
        goto(10); p1_btn = 4'b0010; tick(); p1_btn = '0;
        goto(13); p2_btn = 4'b1000; tick(); p2_btn = '0;
        finish_round(14 + SL);

        // Foul: p1 presses during countdown
        start_round('{p1: 4'b0000, p2: 4'b0100, f1: 1'b1, f2: 1'b0});
        goto(3); p1_btn = 4'b0001; tick(); p1_btn = '0;
        goto(9);
        chk("foul_sticky", 32'(p1_foul), 32'd1);
        goto(12); p2_btn = 4'b0100; tick(); p2_btn = '0;
        finish_round(13 + SL);

        // Reset mid-DRAW with a live foul flag
        start_round('{p1: 4'b0000, p2: 4'b0000, f1: 1'b0, f2: 1'b0});
        goto(4); p1_btn = 4'b0001; tick(); p1_btn = '0;
        goto(15);
        chk("pre_rst_foul", 32'(p1_foul), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_foul", 32'(p1_foul), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(choice_valid), 32'd0);
        void'(sb.pop_back());
        #2 rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Timeout: no presses
        start_round('{p1: 4'b0000, p2: 4'b0000, f1: 1'b0, f2: 1'b0});
        finish_round(25);

        // Multi-bit press and a button held since IDLE
        p2_btn = 4'b0001;
        tick(); tick();
        start_round('{p1: 4'b0010, p2: 4'b0000, f1: 1'b0, f2: 1'b0});
        goto(11); p1_btn = 4'b0110; tick(); p1_btn = '0;
        finish_round(25);
        p2_btn = '0;
        tick();

        // Both lock on the last window cycle; start during DRAW is ignored
        start_round('{p1: 4'b1000, p2: 4'b0010, f1: 1'b0, f2: 1'b0});
        goto(12); start = 1'b1; tick(); start = 1'b0;
        goto(24 - SL); p1_btn = 4'b1000; p2_btn = 4'b0010; tick();
        p1_btn = '0; p2_btn = '0;
        finish_round(25);
        tick(); tick(); tick();
        chk("no_restart", 32'(busy), 32'd0);

        // Press on the COUNTDOWN->DRAW transition cycle is a foul
        start_round('{p1: 4'b0100, p2: 4'b0000, f1: 1'b0, f2: 1'b1});
        goto(8 - SL); p2_btn = 4'b0001; tick(); p2_btn = '0;
        goto(9); p1_btn = 4'b0100; tick(); p1_btn = '0;
        finish_round(10 + SL);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
